riscv_fetch_unit: RTL

Parametrised instruction-fetch front end for the iiitb RISC-V pipeline. It replaces hierarchical MEM/PC preloading with a program-load port. It holds a word-addressed instruction memory, a fetch PC and a FIFO instruction queue. It delivers {pc, instruction} pairs to decode over a valid/ready handshake and supports branch redirect with flush.

---
 rtl/riscv_fetch_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: program-loadable word memory, fetch PC and FIFO queue
// delivering {pc, instruction} over valid/ready. Define FETCH_PERF_EN for perf counters.
module riscv_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 64,
    parameter int              FQ_DEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [XLEN-1:0]               load_data,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [XLEN-1:0]               inst_data,
    output logic [XLEN-1:0]               inst_pc,
    output logic [XLEN-1:0]               fetch_pc,
    output logic [$clog2(FQ_DEPTH):0]     fq_count,
    output logic                          misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                   perf_fetch_cnt,
    output logic [15:0]                   perf_flush_cnt
`endif
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW:0]     FQ_FULL = (CW + 1)'(FQ_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] imem [IMEM_DEPTH];
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] rd_pc;
    logic            inflight;

    logic [XLEN-1:0] q_data [FQ_DEPTH];
    logic [XLEN-1:0] q_pc   [FQ_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            issue;
    logic            push;
    logic            pop;
    logic [CW:0]     occupancy;

    // The in-flight read reserves a queue slot so a push can never overflow.
    always_comb begin
        occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
        issue     = run && !load_en && !redirect_valid && !misalign_err &&
                    (occupancy < FQ_FULL);
        push      = inflight && !redirect_valid;
        pop       = inst_valid && inst_ready && !redirect_valid;
    end

    assign inst_valid = (count != '0);
    assign fq_count   = count;
    assign inst_data  = inst_valid ? q_data[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? q_pc[rd_ptr]   : '0;

    // Memory is intentionally not reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (load_en) begin
            imem[load_addr] <= load_data;
        end
        if (issue) begin
            rd_data <= imem[fetch_pc[AW+1:2]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc     <= RESET_PC;
            rd_pc        <= '0;
            inflight     <= 1'b0;
            misalign_err <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                misalign_err <= 1'b1;
            end
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + PC_STEP;
                rd_pc    <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= rd_data;
            q_pc[wr_ptr]   <= rd_pc;
        end
    end

    // A redirect flushes the queue by rewinding both pointers and the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (push && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
